// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction memory request/ready handshake between fetch unit and imem
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  modport master (output imem_req, imem_addr, input imem_rdata, imem_ready);
  modport slave (input imem_req, imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register and fetch stage; holds one instruction for decode until commit
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0040_0000,
  parameter logic [31:0] EXC_PC      = 32'h8000_0180,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master imem,
  input  logic [1:0]         PCSrc,
  input  logic               Branch,
  input  logic               Zero,
  input  logic [31:0]        jr_target,
  input  logic               commit,
  output logic [31:0]        instr,
  output logic [5:0]         OpCode,
  output logic [5:0]         Funct,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               exc,
  output logic               fetch_err
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] T_MAX  = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYC - 1);
  typedef enum logic [1:0] {IDLE, REQ, EXEC} state_t;
  state_t r_state, w_next;
  logic [31:0] r_pc, r_instr, w_next_pc, w_br_tgt;
  logic [CW-1:0] r_cnt;
  logic r_err, w_commit, w_stall, w_jr_bad;
  assign w_commit = r_state == EXEC && commit;
  assign w_stall  = r_state == REQ && !imem.imem_ready;
  assign w_jr_bad = |jr_target[1:0];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? REQ :
             (r_state == REQ && imem.imem_ready) ? EXEC :
             w_commit ? REQ : r_state;
  end
  assign pc_plus4 = r_pc + 32'd4;
  assign w_br_tgt = pc_plus4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  always_comb begin
    w_next_pc = pc_plus4;
    w_next_pc = PCSrc == 2'b01 ? {pc_plus4[31:28], r_instr[25:0], 2'b00} :
                PCSrc == 2'b10 ? (w_jr_bad ? EXC_PC : jr_target) :
                (PCSrc == 2'b00 && Branch && Zero) ? w_br_tgt : pc_plus4;
  end
  // Timeout counter saturates at TIMEOUT_CYC so the sticky error fires exactly once per stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == REQ && imem.imem_ready) r_instr <= imem.imem_rdata;
      if (w_commit) r_pc <= w_next_pc;
      r_cnt <= w_stall ? (r_cnt == T_MAX ? r_cnt : r_cnt + CW'(1)) : '0;
      if (w_stall && r_cnt == T_LAST) r_err <= 1'b1;
    end
  end
  assign imem.imem_req  = r_state == REQ;
  assign imem.imem_addr = r_pc;
  assign instr       = r_instr;
  assign OpCode      = r_instr[31:26];
  assign Funct       = r_instr[5:0];
  assign instr_valid = r_state == EXEC;
  assign pc          = r_pc;
  assign exc         = w_commit && PCSrc == 2'b10 && w_jr_bad;
  assign fetch_err   = r_err;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench; expected fetch addresses queued at commit, checked at request
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] EXC_PC   = 32'h8000_0180;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] PCSrc = 2'b00;
  logic Branch = 1'b0, Zero = 1'b0, commit = 1'b0;
  logic [31:0] jr_target = '0;
  logic [31:0] instr, pc, pc_plus4;
  logic [5:0] OpCode, Funct;
  logic instr_valid, exc, fetch_err;
  logic [31:0] q[$];
  logic [31:0] cur_pc, cur_instr;
  int checks = 0, errors = 0;

  instr_fetch_unit_if imem_bus();

  instr_fetch_unit #(.RESET_PC(RESET_PC), .EXC_PC(EXC_PC), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .imem(imem_bus), .PCSrc(PCSrc), .Branch(Branch), .Zero(Zero),
    .jr_target(jr_target), .commit(commit), .instr(instr), .OpCode(OpCode), .Funct(Funct),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .exc(exc), .fetch_err(fetch_err));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
      input logic [1:0] src, input logic br, input logic z, input logic [31:0] jr);
    logic [31:0] p4;
    p4 = p + 32'd4;
    if (src == 2'b01) return {p4[31:28], ins[25:0], 2'b00};
    if (src == 2'b10) return (jr % 4 == 0) ? jr : EXC_PC;
    if (src == 2'b00 && br && z) return p4 + 32'(int'($signed(ins[15:0])) * 4);
    return p4;
  endfunction

  task automatic fetch(input int delay, input logic [31:0] word);
    int n = 0;
    logic [31:0] exp;
    while (imem_bus.imem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL fetch_wait: imem_req=%b required 1 within 40 cycles", imem_bus.imem_req);
      return;
    end
    exp = q.size() > 0 ? q.pop_front() : 32'hDEAD_BEEF;
    checks++;
    if (imem_bus.imem_addr !== exp) begin
      errors++;
      $display("FAIL fetch_addr: imem_addr=%h required %h", imem_bus.imem_addr, exp);
    end
    for (int i = 0; i < delay; i++) begin
      imem_bus.imem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== exp || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL req_hold: req=%b addr=%h valid=%b required 1 %h 0",
                 imem_bus.imem_req, imem_bus.imem_addr, instr_valid, exp);
      end
    end
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_rdata = word;
    @(negedge clk);
    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_rdata = $urandom;
    checks++;
    if (instr_valid !== 1'b1 || instr !== word || OpCode !== word[31:26] || Funct !== word[5:0] ||
        imem_bus.imem_req !== 1'b0 || pc !== exp) begin
      errors++;
      $display("FAIL fetch_data: valid=%b instr=%h op=%h fn=%h req=%b pc=%h required 1 %h %h %h 0 %h",
               instr_valid, instr, OpCode, Funct, imem_bus.imem_req, pc, word, word[31:26], word[5:0], exp);
    end
    cur_pc = exp;
    cur_instr = word;
  endtask

  task automatic commit_op(input logic [1:0] src, input logic br, input logic z, input logic [31:0] jr);
    logic [31:0] exp;
    logic exp_exc;
    exp = model_next(cur_pc, cur_instr, src, br, z, jr);
    exp_exc = src == 2'b10 && jr[1:0] != 2'b00;
    PCSrc = src; Branch = br; Zero = z; jr_target = jr; commit = 1'b1;
    #1;
    checks++;
    if (exc !== exp_exc || pc_plus4 !== cur_pc + 32'd4) begin
      errors++;
      $display("FAIL commit_cycle: exc=%b pc_plus4=%h required %b %h", exc, pc_plus4, exp_exc, cur_pc + 32'd4);
    end
    @(negedge clk);
    commit = 1'b0;
    PCSrc = 2'($urandom); Branch = 1'($urandom); Zero = 1'($urandom); jr_target = $urandom;
    checks++;
    if (pc !== exp || instr_valid !== 1'b0 || imem_bus.imem_req !== 1'b1 || exc !== 1'b0) begin
      errors++;
      $display("FAIL after_commit: pc=%h valid=%b req=%b exc=%b required %h 0 1 0",
               pc, instr_valid, imem_bus.imem_req, exc, exp);
    end
    q.push_back(exp);
  endtask

  task automatic expect_pc(input string name, input logic [31:0] want);
    checks++;
    if (pc !== want) begin
      errors++;
      $display("FAIL %s: pc=%h required %h", name, pc, want);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (pc !== RESET_PC || instr !== 32'h0 || OpCode !== 6'h0 || Funct !== 6'h0 || instr_valid !== 1'b0 ||
        imem_bus.imem_req !== 1'b0 || exc !== 1'b0 || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: pc=%h instr=%h valid=%b req=%b exc=%b err=%b required %h 0 0 0 0 0",
               name, pc, instr, instr_valid, imem_bus.imem_req, exc, fetch_err, RESET_PC);
    end
  endtask

  task automatic test_reset;
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_rdata = 32'hFFFF_FFFF;
    commit = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    commit = 1'b0;
    imem_bus.imem_ready = 1'b0;
    reset = 1'b0;
    q.delete();
    q.push_back(RESET_PC);
  endtask

  task automatic test_sequential;
    @(negedge clk);
    checks++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h required 1 %h", imem_bus.imem_req, imem_bus.imem_addr, RESET_PC);
    end
    fetch(0, 32'h2008_0001);
    commit_op(2'b00, 1'b0, 1'b0, 32'h0);
    expect_pc("seq1", 32'h0040_0004);
    fetch(0, 32'h0109_5020);
    commit_op(2'b00, 1'b0, 1'b1, 32'h0);
    expect_pc("seq2", 32'h0040_0008);
    fetch(0, 32'h8D0A_0004);
    commit_op(2'b00, 1'b0, 1'b0, 32'h0);
    expect_pc("seq3", 32'h0040_000C);
  endtask

  task automatic test_wait_states;
    fetch(5, 32'h0000_0000);
    checks++;
    if (fetch_err !== 1'b0) begin errors++; $display("FAIL err_after5: fetch_err=%b required 0", fetch_err); end
    commit_op(2'b00, 1'b0, 1'b0, 32'h0);
    fetch(15, 32'h0000_0020);
    checks++;
    if (fetch_err !== 1'b0) begin errors++; $display("FAIL err_after15: fetch_err=%b required 0", fetch_err); end
    commit_op(2'b00, 1'b0, 1'b0, 32'h0);
    fetch(16, 32'h0000_0022);
    checks++;
    if (fetch_err !== 1'b1) begin errors++; $display("FAIL err_after16: fetch_err=%b required 1", fetch_err); end
    commit_op(2'b00, 1'b0, 1'b0, 32'h0);
    fetch(0, 32'h0000_0024);
    checks++;
    if (fetch_err !== 1'b1) begin errors++; $display("FAIL err_sticky: fetch_err=%b required 1", fetch_err); end
    commit_op(2'b00, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_branch;
    fetch(0, 32'h0000_0008);
    commit_op(2'b10, 1'b0, 1'b0, 32'h0040_0010);
    fetch(1, 32'h1022_FFFE);
    commit_op(2'b00, 1'b1, 1'b1, 32'h0);
    expect_pc("beq_taken", 32'h0040_000C);
    fetch(0, 32'h0000_0008);
    commit_op(2'b10, 1'b0, 1'b0, 32'h0040_0010);
    fetch(2, 32'h1022_FFFE);
    commit_op(2'b00, 1'b1, 1'b0, 32'h0);
    expect_pc("beq_not_taken", 32'h0040_0014);
    fetch(0, 32'h1022_0010);
    commit_op(2'b00, 1'b0, 1'b1, 32'h0);
    expect_pc("branch0_zero1", 32'h0040_0018);
  endtask

  task automatic test_jumps;
    fetch(0, 32'h0000_0008);
    commit_op(2'b10, 1'b0, 1'b0, 32'h0040_0020);
    fetch(0, 32'h0810_0003);
    commit_op(2'b01, 1'b1, 1'b1, 32'h0);
    expect_pc("j_target", 32'h0040_000C);
    fetch(0, 32'h0320_0008);
    commit_op(2'b10, 1'b0, 1'b0, 32'h0040_0100);
    expect_pc("jr_aligned", 32'h0040_0100);
    fetch(0, 32'h0320_0008);
    commit_op(2'b10, 1'b0, 1'b0, 32'h0040_0102);
    expect_pc("jr_misaligned", EXC_PC);
    fetch(0, 32'h0000_000C);
    commit_op(2'b11, 1'b1, 1'b1, 32'h0000_1000);
    expect_pc("reserved_src", EXC_PC + 32'd4);
  endtask

  task automatic test_wrap;
    fetch(0, 32'h0000_0008);
    commit_op(2'b10, 1'b0, 1'b0, 32'hFFFF_FFFC);
    fetch(0, 32'h0000_0000);
    commit_op(2'b00, 1'b0, 1'b0, 32'h0);
    expect_pc("pc_wrap", 32'h0000_0000);
    checks++;
    if (fetch_err !== 1'b1) begin errors++; $display("FAIL err_before_reset: fetch_err=%b required 1", fetch_err); end
  endtask

  task automatic test_reset_mid;
    imem_bus.imem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("reset_in_req");
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    q.push_back(RESET_PC);
    fetch(1, 32'h0810_0003);
    PCSrc = 2'b01; commit = 1'b1; reset = 1'b1;
    #1 check_reset_outputs("reset_in_exec");
    @(posedge clk);
    #1 check_reset_outputs("reset_commit_edge");
    @(negedge clk);
    reset = 1'b0;
    commit = 1'b0;
    q.delete();
    q.push_back(RESET_PC);
    fetch(0, 32'h2008_0005);
  endtask

  task automatic test_commit_in_req;
    commit_op(2'b00, 1'b0, 1'b0, 32'h0);
    PCSrc = 2'b10; jr_target = 32'h1234_5678; commit = 1'b1;
    fetch(4, 32'hAC0A_0010);
    commit = 1'b0;
    expect_pc("commit_in_req", 32'h0040_0004);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'hAC0A_0010 || pc !== 32'h0040_0004) begin
        errors++;
        $display("FAIL exec_hold: valid=%b instr=%h pc=%h required 1 ac0a0010 00400004", instr_valid, instr, pc);
      end
    end
    commit_op(2'b00, 1'b0, 1'b0, 32'h0);
    expect_pc("after_hold", 32'h0040_0008);
    fetch(0, 32'h0000_0000);
  endtask

  initial begin
    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_rdata = '0;
    cur_pc = RESET_PC;
    cur_instr = '0;
    test_reset;
    test_sequential;
    test_wait_states;
    test_branch;
    test_jumps;
    test_wrap;
    test_reset_mid;
    test_commit_in_req;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
